// File: rtl/exe_pkg.sv
// ----------------------------------------------------------------------------
// exe_pkg
// Shared definitions for the execute-stage FP sequencer:
//   - ALU control encodings of the FP add/subtract operations
//   - SYSTEM opcode (CSR/ecall class instructions must never launch the FPU)
//   - canonical quiet NaN returned when the FP unit stops responding
//   - sequencer state encoding
//   - helper that decodes "this EX instruction is an FP add/sub"
// ----------------------------------------------------------------------------
package exe_pkg;

    localparam logic [4:0]  ALU_CTRL_FADD = 5'd22;
    localparam logic [4:0]  ALU_CTRL_FSUB = 5'd23;
    localparam logic [6:0]  OP_SYSTEM     = 7'b1110011;
    localparam logic [31:0] FP_QNAN       = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } fp_sched_state_e;

    // True when the EX slot holds a valid FADD/FSUB that is not a SYSTEM
    // instruction (a CSR op may reuse the same ALU control encoding).
    function automatic logic is_fp_op(input logic       valid,
                                      input logic [6:0] op,
                                      input logic [4:0] alu_ctrl);
        logic ctrl_hit;
        ctrl_hit = (alu_ctrl == ALU_CTRL_FADD) | (alu_ctrl == ALU_CTRL_FSUB);
        return valid & (op != OP_SYSTEM) & ctrl_hit;
    endfunction

endpackage

// File: rtl/exe_lat_counter.sv
// ----------------------------------------------------------------------------
// exe_lat_counter
// Clearable, loadable, enabled up-counter with a registered terminal-count
// flag. Used as the FP latency watchdog.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   clr_i    in   force the count to 0 (highest priority)
//   start_i  in   load the count with 1 (first cycle of an operation)
//   en_i     in   increment the count
//   tc_o     out  registered flag, 1 while the count equals MAX_CNT
// ----------------------------------------------------------------------------
module exe_lat_counter #(
    parameter int unsigned MAX_CNT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic start_i,
    input  logic en_i,
    output logic tc_o
);

    // One spare count above MAX_CNT so an increment at terminal count
    // cannot wrap back into range.
    localparam int unsigned CW = $clog2(MAX_CNT + 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tc_q;
    logic          tc_d;

    // Next count: clear beats load beats increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CW{1'b0}};
        end else if (start_i) begin
            cnt_d = CW'(1);
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        tc_d = (cnt_d == CW'(MAX_CNT));
    end

    // Count and terminal-count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign tc_o = tc_q;

endmodule

// File: rtl/fp_exe_sched.sv
// ----------------------------------------------------------------------------
// fp_exe_sched
// Execute-stage sequencer for multi-cycle FADD/FSUB. Launches the FP unit,
// stalls the pipeline until it completes, captures the result for the EX
// result selector, drains a flushed operation, and guards the FP unit with a
// latency watchdog.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   E_valid/E_op/E_alu_ctrl       EX instruction qualifiers
//   E_rs1_data/E_rs2_data         operands
//   E_hold                        EX frozen by a downstream stall
//   E_flush                       kill the EX instruction
//   fpu_start/fpu_sub/fpu_a/fpu_b launch interface to the FP unit
//   fpu_done/fpu_result           completion interface from the FP unit
//   E_alu_f                       captured FP result
//   E_fp_stall                    stall request to the hazard unit
//   fp_timeout                    sticky watchdog error
//   busy_cycles                   cycles spent in BUSY (wrapping)
// ----------------------------------------------------------------------------
module fp_exe_sched
    import exe_pkg::*;
#(
    parameter int unsigned MAX_LAT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             E_valid,
    input  logic [6:0]       E_op,
    input  logic [4:0]       E_alu_ctrl,
    input  logic [31:0]      E_rs1_data,
    input  logic [31:0]      E_rs2_data,
    input  logic             E_hold,
    input  logic             E_flush,
    output logic             fpu_start,
    output logic             fpu_sub,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    input  logic             fpu_done,
    input  logic [31:0]      fpu_result,
    output logic [31:0]      E_alu_f,
    output logic             E_fp_stall,
    output logic             fp_timeout,
    output logic [CNT_W-1:0] busy_cycles
);

    fp_sched_state_e state_q;
    fp_sched_state_e state_d;

    logic             fpu_start_q, fpu_start_d;
    logic             fpu_sub_q,   fpu_sub_d;
    logic [31:0]      fpu_a_q,     fpu_a_d;
    logic [31:0]      fpu_b_q,     fpu_b_d;
    logic [31:0]      alu_f_q,     alu_f_d;
    logic             timeout_q,   timeout_d;
    logic [CNT_W-1:0] busy_q,      busy_d;

    logic is_fp_s;
    logic launch_s;
    logic stall_s;
    logic capture_s;
    logic nan_s;
    logic timeout_set_s;
    logic lat_clr_s;
    logic lat_en_s;
    logic lat_tc_s;

    assign is_fp_s  = is_fp_op(E_valid, E_op, E_alu_ctrl);
    // Launch only from IDLE, so an instruction parked in DONE is never
    // started a second time.
    assign launch_s = (state_q == IDLE) & is_fp_s & ~E_flush;

    // Watchdog: loaded with 1 at launch so it reads 1 in the fpu_start
    // cycle; counts through BUSY and DRAIN; idles at 0 elsewhere.
    assign lat_en_s  = (state_q == BUSY) | (state_q == DRAIN);
    assign lat_clr_s = (state_q == DONE) | ((state_q == IDLE) & ~launch_s);

    exe_lat_counter #(
        .MAX_CNT (MAX_LAT)
    ) u_lat_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (lat_clr_s),
        .start_i (launch_s),
        .en_i    (lat_en_s),
        .tc_o    (lat_tc_s)
    );

    // Next-state, stall request and result-capture decisions.
    always_comb begin
        state_d       = state_q;
        stall_s       = 1'b0;
        capture_s     = 1'b0;
        nan_s         = 1'b0;
        timeout_set_s = 1'b0;
        case (state_q)
            IDLE: begin
                stall_s = launch_s;
                if (launch_s) begin
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                stall_s = 1'b1;
                if (fpu_done) begin
                    // A result arriving together with a flush is dropped.
                    if (E_flush) begin
                        state_d = IDLE;
                    end else begin
                        capture_s = 1'b1;
                        state_d   = DONE;
                    end
                end else if (lat_tc_s) begin
                    timeout_set_s = 1'b1;
                    if (E_flush) begin
                        state_d = IDLE;
                    end else begin
                        nan_s   = 1'b1;
                        state_d = DONE;
                    end
                end else if (E_flush) begin
                    // FP unit cannot be cancelled: wait out its completion.
                    state_d = DRAIN;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                stall_s = 1'b0;
                if (E_hold & ~E_flush) begin
                    state_d = DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                // Only a new FP instruction has to wait for the old one.
                stall_s = is_fp_s;
                if (fpu_done) begin
                    state_d = IDLE;
                end else if (lat_tc_s) begin
                    timeout_set_s = 1'b1;
                    state_d       = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                stall_s = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Next values of the launch registers, result, error flag and counter.
    always_comb begin
        fpu_start_d = launch_s;
        fpu_sub_d   = fpu_sub_q;
        fpu_a_d     = fpu_a_q;
        fpu_b_d     = fpu_b_q;
        alu_f_d     = alu_f_q;
        timeout_d   = timeout_q | timeout_set_s;
        busy_d      = busy_q;
        if (launch_s) begin
            fpu_sub_d = (E_alu_ctrl == ALU_CTRL_FSUB);
            fpu_a_d   = E_rs1_data;
            fpu_b_d   = E_rs2_data;
        end else begin
            fpu_sub_d = fpu_sub_q;
            fpu_a_d   = fpu_a_q;
            fpu_b_d   = fpu_b_q;
        end
        if (capture_s) begin
            alu_f_d = fpu_result;
        end else if (nan_s) begin
            alu_f_d = FP_QNAN;
        end else begin
            alu_f_d = alu_f_q;
        end
        if (state_q == BUSY) begin
            busy_d = busy_q + CNT_W'(1);
        end else begin
            busy_d = busy_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fpu_start_q <= 1'b0;
            fpu_sub_q   <= 1'b0;
            fpu_a_q     <= 32'h0000_0000;
            fpu_b_q     <= 32'h0000_0000;
            alu_f_q     <= 32'h0000_0000;
            timeout_q   <= 1'b0;
            busy_q      <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            fpu_start_q <= fpu_start_d;
            fpu_sub_q   <= fpu_sub_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            alu_f_q     <= alu_f_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    assign fpu_start   = fpu_start_q;
    assign fpu_sub     = fpu_sub_q;
    assign fpu_a       = fpu_a_q;
    assign fpu_b       = fpu_b_q;
    assign E_alu_f     = alu_f_q;
    assign fp_timeout  = timeout_q;
    assign busy_cycles = busy_q;
    // The stall path is combinational from EX inputs; gating with rst_n
    // keeps it low while the block is held in reset.
    assign E_fp_stall  = rst_n & stall_s;

endmodule
